// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store sequencing controller between execute and the data
// memory bus.
//
// Accepts one load or store at a time, checks funct3 legality and alignment,
// builds byte strobes and lane-replicated write data, runs a req/gnt/rvalid
// bus handshake and returns exactly one response per request (extended load
// data or an error). A timeout aborts requests stuck in REQ/WAIT.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   req_valid/req_ready     request handshake from execute
//   req_we                  1=store, 0=load
//   req_func3               RV32I funct3 (SB/SH/SW, LB/LH/LW/LBU/LHU)
//   req_addr                effective byte address
//   req_wdata               store data, low-aligned
//   bus_req/bus_gnt         bus request / grant
//   bus_addr                word-aligned bus address
//   bus_we/bus_wstrb        write enable / byte strobes (0 for loads)
//   bus_wdata               lane-replicated write data
//   bus_rvalid/bus_rdata    response strobe / read word
//   rsp_valid               one-cycle completion pulse
//   rsp_err                 misaligned, illegal funct3 or timeout
//   rsp_rdata               extended load data (0 for stores and errors)
//   busy                    controller not idle
// ---------------------------------------------------------------------------

// Per-byte-lane store formatting: strobe and data byte for one lane.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic       we,
  input  logic [1:0] size,     // funct3[1:0]: 0=byte 1=half 2=word
  input  logic [1:0] ofs,      // addr[1:0]
  input  logic [7:0] sb_byte,  // byte source for SB
  input  logic [7:0] sh_byte,  // half byte that lands on this lane for SH
  input  logic [7:0] sw_byte,  // this lane's byte of the word for SW
  output logic       strb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    strb  = 1'b0;
    wbyte = sb_byte;
    case (size)
      2'b00: begin
        strb  = (ofs == L);
        wbyte = sb_byte;
      end
      // Halves are aligned by the time they reach the bus, so the upper
      // offset bit alone picks the lane pair.
      2'b01: begin
        strb  = (ofs[1] == L[1]);
        wbyte = sh_byte;
      end
      default: begin
        strb  = 1'b1;
        wbyte = sw_byte;
      end
    endcase
    if (!we) strb = 1'b0;
  end
endmodule

module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // The part of the request still needed after it has been put on the bus.
  typedef struct packed {
    logic       we;
    logic [2:0] func3;
    logic [1:0] ofs;
  } req_t;

  state_t     state, state_nxt;
  req_t       cur;
  logic [CNT_W-1:0] cnt;

  logic illegal, misalign, req_bad, tmo;

  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // -------------------------------------------------------------------------
  // Request checks (on the incoming request, used only in IDLE)
  // -------------------------------------------------------------------------
  always_comb begin
    if (req_we) illegal = req_func3[2] | (req_func3[1:0] == 2'b11);
    else        illegal = (req_func3[1:0] == 2'b11) | (req_func3 == 3'b110);
    misalign = ((req_func3[1:0] == 2'b01) &  req_addr[0]) |
               ((req_func3[1:0] == 2'b10) & |req_addr[1:0]);
    req_bad  = illegal | misalign;
  end

  // >= rather than == so that a grant on the last REQ cycle still leaves
  // WAIT bounded: the very next WAIT cycle without rvalid aborts.
  assign tmo = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // -------------------------------------------------------------------------
  // Store lane formatting, one instance per byte lane
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .we      (req_we),
      .size    (req_func3[1:0]),
      .ofs     (req_addr[1:0]),
      .sb_byte (req_wdata[7:0]),
      .sh_byte (req_wdata[8*(i%2) +: 8]),
      .sw_byte (req_wdata[8*i +: 8]),
      .strb    (lane_strb[i]),
      .wbyte   (lane_wdata[i])
    );
  end

  // -------------------------------------------------------------------------
  // Load extraction from the returned word
  // -------------------------------------------------------------------------
  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (cur.ofs)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = cur.ofs[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    load_data = bus_rdata;
    case (cur.func3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = bus_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = req_bad ? S_RESP : S_REQ;
      S_REQ: begin
        if (bus_gnt)  state_nxt = S_WAIT;
        else if (tmo) state_nxt = S_RESP;
      end
      S_WAIT: begin
        if (bus_rvalid) state_nxt = S_RESP;
        else if (tmo)   state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: combinational outputs
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Registered datapath: bus drive, timeout counter, response
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= '0;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // rsp_valid is high only in the cycle the FSM sits in RESP
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur <= '{we: req_we, func3: req_func3, ofs: req_addr[1:0]};
            cnt <= '0;
            if (req_bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_we    <= req_we;
              bus_wstrb <= lane_strb;
              bus_wdata <= lane_wdata;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
          end else if (tmo) begin
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= cur.we ? 32'h0 : load_data;
          end else if (tmo) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl (TIMEOUT_CYCLES=8).
// Directed cases from the plan followed by randomized transactions, all
// checked against a byte-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (f3[1:0] == 2'b11) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if (!we && f3 == 3'b110) return 1'b1;
    nbytes = 1 << f3[1:0];
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    logic [31:0] s;
    nbytes = 1 << f3[1:0];
    s = ((32'd1 << nbytes) - 32'd1) << (a % 4);
    return we ? s[3:0] : 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {24'h0, wd[7:0]}  * 32'h0101_0101;
      2'b01:   return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int nbytes;
    logic [31:0] v, mask;
    nbytes = 1 << f3[1:0];
    v = rd >> (8 * (a % 4));
    if (nbytes == 4) return v;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
    return v;
  endfunction

  // Present a request in the current (IDLE) cycle; returns in cycle T+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Full transaction with a well-behaved bus (no timeout).
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input int rv_wait,
                        input logic [31:0] rd, input logic rv_in_gnt);
    logic [31:0] exp_rd;
    int lat;
    chk1("idle_ready", req_ready, 1'b1);
    issue(we, f3, a, wd);
    lat = 1;
    if (m_err(we, f3, a)) begin
      chk1("err_rsp_valid", rsp_valid, 1'b1);
      chk1("err_flag", rsp_err, 1'b1);
      chk("err_rdata", rsp_rdata, 32'h0);
      chk1("err_no_bus", bus_req, 1'b0);
      step();
      chk1("err_pulse_end", rsp_valid, 1'b0);
      chk1("err_back_idle", req_ready, 1'b1);
      return;
    end
    for (int i = 0; i <= gnt_dly; i++) begin
      chk1("req_bus_req", bus_req, 1'b1);
      chk("req_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk1("req_bus_we", bus_we, we);
      chk("req_wstrb", {28'h0, bus_wstrb}, {28'h0, m_strb(we, f3, a)});
      if (we) chk("req_wdata", bus_wdata, m_wdata(f3, wd));
      chk1("req_not_ready", req_ready, 1'b0);
      chk1("req_no_rsp", rsp_valid, 1'b0);
      if (i == gnt_dly) begin
        bus_gnt = 1'b1;
        if (rv_in_gnt) begin bus_rvalid = 1'b1; bus_rdata = ~rd; end
      end
      step(); lat++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    chk1("gnt_drop", bus_req, 1'b0);
    for (int i = 0; i < rv_wait; i++) begin
      chk1("wait_no_rsp", rsp_valid, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      step(); lat++;
    end
    chk1("wait_no_rsp_last", rsp_valid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = rd;
    step(); lat++;
    bus_rvalid = 1'b0; bus_rdata = $urandom;
    exp_rd = we ? 32'h0 : m_load(f3, a, rd);
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk1("rsp_err", rsp_err, 1'b0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("latency", lat, 3 + gnt_dly + rv_wait);
    step();
    chk1("rsp_pulse_end", rsp_valid, 1'b0);
    chk("rsp_rdata_hold", rsp_rdata, exp_rd);
    chk1("back_ready", req_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = '0; req_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // ---- reset state ----
    step(); step();
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    // ---- directed lane / extension cases ----
    do_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'hDEAD_BEEF, 1'b0);
    chk("sb_strb_const", {28'h0, bus_wstrb}, 32'h8);
    chk("sb_wdata_const", bus_wdata, 32'hABAB_ABAB);
    do_txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_80FF, 1'b0);
    chk("lb_const", rsp_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_80FF, 1'b0);
    chk("lbu_const", rsp_rdata, 32'h0000_0080);
    do_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_0000, 1'b0);
    chk("lh_const", rsp_rdata, 32'hFFFF_8001);
    do_txn(1'b1, 3'b001, 32'h0000_3002, 32'h1234_C0DE, 1, 0, 32'h0, 1'b0);
    do_txn(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 0, 1, 32'h0, 1'b0);

    // ---- errors detected in IDLE ----
    do_txn(1'b1, 3'b001, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_1002, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(1'b1, 3'b011, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0);

    // ---- grant stall with a stray rvalid in the grant cycle ----
    do_txn(1'b0, 3'b010, 32'h0000_4008, 32'h0, 3, 1, 32'h0BAD_F00D, 1'b1);

    // ---- completing events on the last counted cycle win ----
    do_txn(1'b0, 3'b101, 32'h0000_5002, 32'h0, TC - 1, 0, 32'hFEDC_BA98, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_5004, 32'h0, 0, TC - 2, 32'h7654_3210, 1'b0);

    // ---- timeout in WAIT, then a late rvalid is ignored ----
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    for (int i = 2; i <= TC; i++) begin
      chk1("tmo_wait_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk1("tmo_wait_rsp", rsp_valid, 1'b1);
    chk1("tmo_wait_err", rsp_err, 1'b1);
    chk("tmo_wait_rdata", rsp_rdata, 32'h0);
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    step();
    bus_rvalid = 1'b0;
    chk1("late_rvalid_no_rsp", rsp_valid, 1'b0);
    chk1("late_rvalid_idle", busy, 1'b0);

    // ---- timeout in REQ (grant never comes) ----
    issue(1'b1, 3'b010, 32'h0000_0044, 32'h5555_AAAA);
    for (int i = 1; i <= TC; i++) begin
      chk1("tmo_req_held", bus_req, 1'b1);
      chk1("tmo_req_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk1("tmo_req_rsp", rsp_valid, 1'b1);
    chk1("tmo_req_err", rsp_err, 1'b1);
    chk1("tmo_req_bus_drop", bus_req, 1'b0);
    step();
    chk1("tmo_req_idle", req_ready, 1'b1);

    // ---- reset while in WAIT ----
    issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk1("wrst_bus_req", bus_req, 1'b0);
    chk1("wrst_rsp_valid", rsp_valid, 1'b0);
    chk1("wrst_ready", req_ready, 1'b1);
    chk1("wrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    do_txn(1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 0, 32'hA5A5_5A5A, 1'b0);

    // ---- randomized transactions ----
    for (int n = 0; n < 60; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      // bias towards aligned addresses so most requests reach the bus
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((32'd1 << r_f3[1:0]) - 32'd1);
      do_txn(r_we, r_f3, r_a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
